mdu_hilo: RTL and testbench
===========================

# mdu_hilo

Iterative multiply/divide unit with the architectural HI/LO registers. It sits downstream of the instruction decoder in the execute stage and serves MULTU, MUL, DIV, DIVU, MTHI and MTLO. MFHI and MFLO read the `hi` and `lo` outputs combinationally. While an operation runs, `busy` stalls the pipeline.

## Interface

Parameters:
- `WIDTH`, 32, operand and HI/LO width. Only 32 is supported.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request strobe, sampled on a rising edge.
- `op`  in  3  operation: 0 MULTU, 1 DIV, 2 DIVU, 3 MUL (signed), 4 MTHI, 5 MTLO; 6 and 7 are reserved.
- `a`  in  32  rs operand (dividend / multiplicand / move source).
- `b`  in  32  rt operand (divisor / multiplier).
- `busy`  out  1  an arithmetic operation is in flight.
- `done`  out  1  one-cycle pulse; HI/LO were updated on the same edge.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation

Reset (`rst_n`=0 at a rising edge):
- `busy`=0, `done`=0, `hi`=0, `lo`=0, iteration counter=0, FSM goes to IDLE.
- Reset takes effect mid-operation; the partial result is discarded.

Accepting a request:
- A request is accepted only in IDLE.
- `start` while `busy`=1 is ignored. The decoder must stall on `busy`.
- `start` with a reserved `op` is ignored: no state change.

MTHI / MTLO:
- Single edge: `hi<=a` or `lo<=a`.
- No FSM transition, `busy` stays 0, no `done` pulse.

Arithmetic ops (MULTU, MUL, DIV, DIVU) use three FSM states:
- IDLE → RUN on an accepted arithmetic `start`:
  - Latch the operands. For signed ops (MUL, DIV), latch their magnitudes.
  - Latch the result signs.
  - Clear the 64-bit accumulator. Clear the counter.
- RUN: 32 iterations, one per cycle; the counter runs 0..31.
  - Multiply: shift-add, LSB first. The 64-bit product is accumulated unsigned on the magnitudes.
  - Divide: restoring, MSB first. This yields a 32-bit quotient and a 32-bit remainder on the magnitudes.
- RUN → FIX when the counter reaches 31.
- FIX: sign correction, then write HI/LO.
  - MUL: negate the 64-bit product if the operand signs differ. Write `hi`=product[63:32], `lo`=product[31:0].
  - MULTU: write `hi`=product[63:32], `lo`=product[31:0].
  - DIV: the quotient is negative iff the operand signs differ. The remainder takes the dividend's sign. Write `lo`=quotient, `hi`=remainder.
  - DIVU: write `lo`=quotient, `hi`=remainder.
  - FIX → IDLE.

Boundary rules:
- Divide by zero (DIV or DIVU, `b`=0): `lo`=0xFFFFFFFF, `hi`=`a` (raw, not sign-corrected). No exception is raised.
- DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0 (wraps; no trap).
- Magnitude of 0x80000000 is 0x80000000, treated as unsigned.
- `hi`/`lo` hold their old values throughout RUN; they are updated only in FIX.

## Timing

- Let E0 be the edge on which `start` is accepted.
- `busy` rises after E0 and is 1 for exactly 33 cycles (E1..E33).
- RUN occupies E1..E32. FIX occupies E33.
- At E33, `hi`/`lo` are written, `busy` drops to 0 and `done` goes to 1. `done` returns to 0 after E34.
- A new `start` may be sampled at E34, i.e. back-to-back with one idle edge minimum.
  - `start` at E33 is ignored, since `busy` is still 1 before E33.
- MTHI/MTLO latency: one edge. The new value is visible on `hi`/`lo` after the accepting edge.
- `hi`/`lo` are combinational register outputs. MFHI in the cycle after `done` reads the new value.

## Test plan

- MULTU `a`=0xFFFFFFFF, `b`=0xFFFFFFFF:
  - `busy` high for 33 cycles.
  - Then `done` for 1 cycle, with `hi`=0xFFFFFFFE, `lo`=0x00000001.
- MUL `a`=0xFFFFFFFD (−3), `b`=7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- DIV `a`=0xFFFFFFF9 (−7), `b`=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU `a`=7, `b`=2 → `lo`=3, `hi`=1.
- Divide corner cases:
  - DIVU `a`=0x1234, `b`=0 → `lo`=0xFFFFFFFF, `hi`=0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Control:
  - MTHI `a`=0xDEADBEEF → `hi`=0xDEADBEEF one edge later; `busy` and `done` stay 0.
  - `start` with DIVU pulsed at cycle 5 of a MULTU is ignored; the MULTU result is unchanged.
  - `rst_n`=0 at cycle 10 of RUN → `busy`=0, `hi`=`lo`=0, no `done` pulse.

Source files
------------

// File: rtl/mdu_hilo_if.sv
// Decoder-to-MDU request/response bundle: operation request in, HI/LO and status out.
interface mdu_hilo_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, a, b, input busy, done, hi, lo);
   modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit owning the HI/LO registers: one bit per cycle over
// operand magnitudes, with sign correction in a final FIX cycle.
module mdu_hilo #(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   mdu_hilo_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [2:0] OP_MULTU = 3'd0;
   localparam logic [2:0] OP_DIV   = 3'd1;
   localparam logic [2:0] OP_DIVU  = 3'd2;
   localparam logic [2:0] OP_MUL   = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;

   logic [1:0]         stateReg;
   logic [CW-1:0]      countReg;
   logic [2:0]         opReg;
   logic [2*WIDTH-1:0] accReg;
   logic [2*WIDTH-1:0] opAReg;
   logic [WIDTH-1:0]   opBReg;
   logic               negResReg;
   logic               negRemReg;
   logic               divZeroReg;
   logic [WIDTH-1:0]   hiReg;
   logic [WIDTH-1:0]   loReg;
   logic               doneReg;

   logic               isDivOp;
   logic               isSignedIn;
   logic               aNeg;
   logic               bNeg;
   logic [WIDTH-1:0]   aMag;
   logic [WIDTH-1:0]   bMag;
   logic [2*WIDTH-1:0] multSum;
   logic [WIDTH:0]     remShift;
   logic [WIDTH+1:0]   divDiff;
   logic               divFits;
   logic [2*WIDTH-1:0] divStep;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;

   always_comb begin
      isDivOp    = (opReg == OP_DIV) || (opReg == OP_DIVU);
      isSignedIn = (bus.op == OP_MUL) || (bus.op == OP_DIV);
      aNeg       = isSignedIn & bus.a[WIDTH-1];
      bNeg       = isSignedIn & bus.b[WIDTH-1];
      aMag       = aNeg ? -bus.a : bus.a;
      bMag       = bNeg ? -bus.b : bus.b;

      // Multiply: multiplicand shifts left, multiplier bits consumed LSB first.
      multSum    = accReg + (opBReg[0] ? opAReg : '0);

      // Restoring divide: remainder in the upper half, quotient shifts into the lower half.
      remShift   = {accReg[2*WIDTH-1:WIDTH], opAReg[WIDTH-1]};
      divDiff    = {1'b0, remShift} - {2'b00, opBReg};
      divFits    = ~divDiff[WIDTH+1];
      divStep    = {divFits ? divDiff[WIDTH-1:0] : remShift[WIDTH-1:0],
                    accReg[WIDTH-2:0], divFits};

      product    = negResReg ? -accReg : accReg;
      quot       = negResReg ? -accReg[WIDTH-1:0] : accReg[WIDTH-1:0];
      rem        = negRemReg ? -accReg[2*WIDTH-1:WIDTH] : accReg[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stateReg   <= IDLE;
         countReg   <= '0;
         opReg      <= OP_MULTU;
         accReg     <= '0;
         opAReg     <= '0;
         opBReg     <= '0;
         negResReg  <= 1'b0;
         negRemReg  <= 1'b0;
         divZeroReg <= 1'b0;
         hiReg      <= '0;
         loReg      <= '0;
         doneReg    <= 1'b0;
      end else begin
         doneReg <= 1'b0;
         case (stateReg)
            IDLE: begin
               if (bus.start) begin
                  case (bus.op)
                     OP_MTHI: hiReg <= bus.a;
                     OP_MTLO: loReg <= bus.a;
                     OP_MULTU, OP_DIV, OP_DIVU, OP_MUL: begin
                        opReg      <= bus.op;
                        opAReg     <= {{WIDTH{1'b0}}, aMag};
                        opBReg     <= bMag;
                        negResReg  <= aNeg ^ bNeg;
                        negRemReg  <= aNeg;
                        divZeroReg <= (bus.b == '0);
                        accReg     <= '0;
                        countReg   <= '0;
                        stateReg   <= RUN;
                     end
                     default: ;
                  endcase
               end
            end
            RUN: begin
               accReg   <= isDivOp ? divStep : multSum;
               opAReg   <= opAReg << 1;
               if (!isDivOp) opBReg <= opBReg >> 1;
               countReg <= countReg + 1'b1;
               if (countReg == LAST) stateReg <= FIX;
            end
            FIX: begin
               if (isDivOp) begin
                  // With a zero divisor the restoring loop leaves |a| as remainder, and the
                  // dividend-sign correction turns that back into the raw a.
                  loReg <= divZeroReg ? '1 : quot;
                  hiReg <= rem;
               end else begin
                  hiReg <= product[2*WIDTH-1:WIDTH];
                  loReg <= product[WIDTH-1:0];
               end
               doneReg  <= 1'b1;
               stateReg <= IDLE;
            end
            default: stateReg <= IDLE;
         endcase
      end
   end

   assign bus.busy = (stateReg != IDLE);
   assign bus.done = doneReg;
   assign bus.hi   = hiReg;
   assign bus.lo   = loReg;
endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: expected HI/LO pushed to a scoreboard at issue, popped on done.
module tb_mdu_hilo;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   typedef struct {
      string       tag;
      logic [31:0] hi;
      logic [31:0] lo;
   } expT;
   expT sbQ[$];

   mdu_hilo_if #(.WIDTH(32)) bus ();
   mdu_hilo #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] av,
                                          input logic [31:0] bv);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic signed [31:0] q;
      logic signed [31:0] r;
      logic signed [63:0] sp;
      sa = av;
      sb = bv;
      case (o)
         3'd0: return {32'b0, av} * {32'b0, bv};
         3'd3: begin
            sp = 64'(sa) * 64'(sb);
            return sp;
         end
         3'd2: begin
            if (bv == 0) return {av, 32'hFFFFFFFF};
            return {av % bv, av / bv};
         end
         default: begin
            if (bv == 0) return {av, 32'hFFFFFFFF};
            if (av == 32'h80000000 && bv == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
            q = sa / sb;
            r = sa % sb;
            return {r, q};
         end
      endcase
   endfunction

   // Issue one arithmetic op and follow it to done; injectAt>=0 pulses a DIVU start
   // on that busy cycle, which must be ignored.
   task automatic runArith(input string tag, input logic [2:0] o, input logic [31:0] av,
                           input logic [31:0] bv, input logic [63:0] expHiLo, input int injectAt);
      int          busyCnt;
      bit          gotDone;
      bit          holdBad;
      logic [31:0] hiBefore;
      logic [31:0] loBefore;
      expT         e;
      sbQ.push_back('{tag, expHiLo[63:32], expHiLo[31:0]});
      @(negedge clk);
      hiBefore  = bus.hi;
      loBefore  = bus.lo;
      bus.start = 1'b1;
      bus.op    = o;
      bus.a     = av;
      bus.b     = bv;
      @(negedge clk);
      bus.start = 1'b0;
      busyCnt = 0;
      gotDone = 0;
      holdBad = 0;
      for (int i = 0; i < 40; i++) begin
         if (i == injectAt + 1) bus.start = 1'b0;
         if (i == injectAt) begin
            bus.start = 1'b1;
            bus.op    = 3'd2;
            bus.a     = 32'd100;
            bus.b     = 32'd7;
         end
         if (bus.done) begin
            gotDone = 1;
            break;
         end
         if (bus.busy) busyCnt++;
         if (bus.hi !== hiBefore || bus.lo !== loBefore) holdBad = 1;
         @(negedge clk);
      end
      bus.start = 1'b0;
      chk({tag, "_busy_cycles"}, 32'(busyCnt), 32'd33);
      chk({tag, "_hold_in_run"}, 32'(holdBad), 32'd0);
      chk({tag, "_done_seen"}, 32'(gotDone), 32'd1);
      if (gotDone) begin
         if (sbQ.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
         end else begin
            e = sbQ.pop_front();
            chk({e.tag, "_hi"}, bus.hi, e.hi);
            chk({e.tag, "_lo"}, bus.lo, e.lo);
            @(negedge clk);
            chk({e.tag, "_done_pulse"}, 32'(bus.done), 32'd0);
            chk({e.tag, "_busy_after"}, 32'(bus.busy), 32'd0);
            chk({e.tag, "_hi_after"}, bus.hi, e.hi);
         end
      end else begin
         void'(sbQ.pop_front());
      end
   endtask

   initial begin
      bit sawDone;
      logic [31:0] ra;
      logic [31:0] rb;
      bus.start = 1'b0;
      bus.op    = 3'd0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_done", 32'(bus.done), 32'd0);
      chk("reset_hi", bus.hi, 32'd0);
      chk("reset_lo", bus.lo, 32'd0);
      rst_n = 1'b1;

      runArith("multu_max", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001}, -1);
      runArith("mul_neg", 3'd3, 32'hFFFFFFFD, 32'd7, {32'hFFFFFFFF, 32'hFFFFFFEB}, -1);
      runArith("div_neg", 3'd1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, -1);
      runArith("divu_7_2", 3'd2, 32'd7, 32'd2, {32'd1, 32'd3}, -1);
      runArith("divu_by0", 3'd2, 32'h1234, 32'd0, {32'h1234, 32'hFFFFFFFF}, -1);
      runArith("div_ovf", 3'd1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, -1);
      runArith("div_neg_by0", 3'd1, 32'hFFFFFF00, 32'd0, {32'hFFFFFF00, 32'hFFFFFFFF}, -1);
      runArith("multu_inject", 3'd0, 32'h00012345, 32'h00006789,
               {32'h00000000, 32'h00012345 * 32'h00006789}, 5);
      runArith("divu_start_e33", 3'd2, 32'd1000, 32'd9, {32'd1, 32'd111}, 32);

      for (int k = 0; k < 8; k++) begin
         ra = $urandom;
         rb = (k == 5) ? 32'(k + 3) : $urandom;
         runArith($sformatf("rand%0d", k), 3'(k % 4), ra, rb, model(3'(k % 4), ra, rb), -1);
      end

      // MTHI / MTLO: single edge, no busy, no done.
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hDEADBEEF;
      @(negedge clk);
      bus.start = 1'b0;
      chk("mthi_hi", bus.hi, 32'hDEADBEEF);
      chk("mthi_busy", 32'(bus.busy), 32'd0);
      chk("mthi_done", 32'(bus.done), 32'd0);
      bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'h5A5A5A5A;
      @(negedge clk);
      bus.start = 1'b0;
      chk("mtlo_lo", bus.lo, 32'h5A5A5A5A);
      chk("mtlo_hi_kept", bus.hi, 32'hDEADBEEF);
      chk("mtlo_done", 32'(bus.done), 32'd0);

      // Reserved op: no state change.
      bus.start = 1'b1; bus.op = 3'd6; bus.a = 32'h11111111; bus.b = 32'h2;
      @(negedge clk);
      bus.start = 1'b0;
      chk("rsvd_busy", 32'(bus.busy), 32'd0);
      chk("rsvd_hi", bus.hi, 32'hDEADBEEF);
      chk("rsvd_lo", bus.lo, 32'h5A5A5A5A);

      // Reset in the middle of RUN discards the operation.
      bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd3; bus.b = 32'd5;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      chk("pre_reset_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_hi", bus.hi, 32'd0);
      chk("midrst_lo", bus.lo, 32'd0);
      rst_n = 1'b1;
      sawDone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done) sawDone = 1;
      end
      chk("midrst_no_done", 32'(sawDone), 32'd0);
      chk("sb_drained", 32'(sbQ.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
